i281_fetch_unit: RTL and testbench

Instruction fetch stage for the i281 CPU. It sits directly downstream of the hardcoded BIOS low/high banks and upstream of the decoder and control unit. It holds the program counter and selects the 16-bit instruction word from the 32-word BIOS space (low bank words 0–15, high bank words 16–31). It registers that word into an instruction register, and handles sequential fetch, relative branches with a one-cycle flush, stalls and halt.

---
 rtl/i281_fetch_pkg.sv | 13 +
 rtl/i281_bios_word_mux.sv | 13 +
 rtl/i281_fetch_unit.sv | 68 ++++++
 tb/tb_i281_fetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/i281_fetch_pkg.sv
// i281_fetch_pkg: shared widths, fetch FSM states, halt offset and branch target arithmetic
package i281_fetch_pkg;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 16;
    localparam logic [7:0] HALT_OFFSET = 8'hFF;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    // Low bits of an 8-bit two's complement add equal the modulo-32 target.
    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc, input logic [7:0] off);
        logic [7:0] sum;
        sum = 8'(pc) + 8'd1 + off;
        return sum[ADDR_W-1:0];
    endfunction
endpackage

// File: rtl/i281_bios_word_mux.sv
// i281_bios_word_mux: selects one 16-bit BIOS word from the low/high banks by 5-bit address
// Ports: bios_low_flat/bios_high_flat (16 words each), addr (5), word (16)
module i281_bios_word_mux
    import i281_fetch_pkg::*;
(
    input  logic [16*WORD_W-1:0] bios_low_flat,
    input  logic [16*WORD_W-1:0] bios_high_flat,
    input  logic [ADDR_W-1:0]    addr,
    output logic [WORD_W-1:0]    word
);
    always_comb word = addr[ADDR_W-1] ? bios_high_flat[{addr[3:0], 4'b0000} +: WORD_W]
                                      : bios_low_flat[{addr[3:0], 4'b0000} +: WORD_W];
endmodule

// File: rtl/i281_fetch_unit.sv
// i281_fetch_unit: PC, BIOS fetch into IR, relative branch with one bubble, stall, optional halt
// Ports: clk, rst (async high), bios_low_flat/bios_high_flat, fetch_en, stall, branch_taken,
//        branch_offset -> pc_out, instr_out, instr_valid, halted
// Macro I281_HALT_DETECT_EN: a taken jump-to-self branch enters HALT; otherwise halted is 0.
module i281_fetch_unit
    import i281_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*WORD_W-1:0] bios_low_flat,
    input  logic [16*WORD_W-1:0] bios_high_flat,
    input  logic                 fetch_en,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [7:0]           branch_offset,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [WORD_W-1:0]    instr_out,
    output logic                 instr_valid,
    output logic                 halted
);
    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [WORD_W-1:0]   word;
    logic                fetch;
    logic                take;
    i281_bios_word_mux u_mux (
        .bios_low_flat (bios_low_flat),
        .bios_high_flat(bios_high_flat),
        .addr          (pc),
        .word          (word)
    );
    // Branch only acts on a live IR word; a squashed slot falls through to a fetch.
    assign take  = state == RUN && fetch_en && branch_taken && instr_valid;
    assign fetch = state != HALT && fetch_en && !take;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            pc_out      <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            if (fetch) begin
                state       <= RUN;
                instr_out   <= word;
                pc_out      <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 1'b1;
            end else if (take) begin
                instr_valid <= 1'b0;
`ifdef I281_HALT_DETECT_EN
                if (branch_offset == HALT_OFFSET) state <= HALT;
                else pc <= branch_target(pc_out, branch_offset);
`else
                pc <= branch_target(pc_out, branch_offset);
`endif
            end else if (state == RUN) begin
                state       <= IDLE;
                instr_valid <= 1'b0;
            end
        end
    end
`ifdef I281_HALT_DETECT_EN
    assign halted = state == HALT;
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_i281_fetch_unit.sv
// tb_i281_fetch_unit: table vectors, directed corner sequences and random stimulus vs a behavioural model
module tb_i281_fetch_unit;
`ifdef I281_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fe = 1'b0, st = 1'b0, br = 1'b0;
    logic [7:0] off = 8'h00;
    logic [31:0][15:0] memp;
    logic [255:0] bios_low_flat, bios_high_flat;
    logic [4:0] pc_out;
    logic [15:0] instr_out;
    logic instr_valid, halted;
    int checks = 0, errors = 0;
    int m_mode, m_pc, m_irpc;
    logic [15:0] m_ir;
    logic m_v;
    typedef struct {
        logic fe, st, br;
        logic [7:0] off;
        logic [4:0] pc;
        logic [15:0] ins;
        logic v;
    } vec_t;
    vec_t vec [12];
    assign bios_low_flat  = memp[15:0];
    assign bios_high_flat = memp[31:16];
    always #5 clk = ~clk;
    i281_fetch_unit dut (
        .clk(clk), .rst(rst), .bios_low_flat(bios_low_flat), .bios_high_flat(bios_high_flat),
        .fetch_en(fe), .stall(st), .branch_taken(br), .branch_offset(off),
        .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid), .halted(halted)
    );
    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got pc/instr/valid/halted=%h required %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_irpc = 0; m_ir = 16'h0000; m_v = 1'b0;
    endtask
    // Mode 0 idle, 1 running, 2 halted; addresses kept as plain integers modulo 32.
    task automatic model_edge(input logic f, input logic s, input logic b, input logic [7:0] o);
        int t;
        if (s || m_mode == 2) return;
        if (m_mode == 1 && f && b && m_v) begin
            m_v = 1'b0;
            if (HALT_EN && o == 8'hFF) m_mode = 2;
            else begin
                t = m_irpc + 1 + int'($signed(o));
                m_pc = ((t % 32) + 32) % 32;
            end
        end else if (f) begin
            m_mode = 1; m_ir = memp[m_pc]; m_irpc = m_pc; m_v = 1'b1; m_pc = (m_pc + 1) % 32;
        end else if (m_mode == 1) begin
            m_mode = 0; m_v = 1'b0;
        end
    endtask
    task automatic step(input logic f, input logic s, input logic b, input logic [7:0] o);
        fe = f; st = s; br = b; off = o;
        @(posedge clk);
        model_edge(f, s, b, o);
        #1;
        check("model", {pc_out, instr_out, instr_valid, halted}, {5'(m_irpc), m_ir, m_v, m_mode == 2});
    endtask
    task automatic run_to(input int target);
        int n = 0;
        while (!(m_v && m_irpc == target) && n < 80) begin
            step(1, 0, 0, 8'h00);
            n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL run_to got pc=%0d required %0d", m_irpc, target);
        end
    endtask
    initial begin
        for (int i = 0; i < 32; i++) memp[i] = 16'($urandom);
        memp[0] = 16'h380C; memp[1] = 16'h120E; memp[5] = 16'hF214;
        vec[0]  = '{1, 0, 0, 8'h00, 5'd0,  16'h380C, 1};
        vec[1]  = '{1, 0, 0, 8'h00, 5'd1,  16'h120E, 1};
        vec[2]  = '{1, 0, 0, 8'h00, 5'd2,  memp[2],  1};
        vec[3]  = '{1, 0, 0, 8'h00, 5'd3,  memp[3],  1};
        vec[4]  = '{1, 0, 0, 8'h00, 5'd4,  memp[4],  1};
        vec[5]  = '{1, 0, 0, 8'h00, 5'd5,  16'hF214, 1};
        vec[6]  = '{1, 0, 1, 8'h14, 5'd5,  16'hF214, 0};
        vec[7]  = '{1, 0, 1, 8'h14, 5'd26, memp[26], 1};
        vec[8]  = '{1, 0, 0, 8'h00, 5'd27, memp[27], 1};
        vec[9]  = '{0, 0, 0, 8'h00, 5'd27, memp[27], 0};
        vec[10] = '{0, 0, 0, 8'h00, 5'd27, memp[27], 0};
        vec[11] = '{1, 0, 0, 8'h00, 5'd28, memp[28], 1};
        model_reset();
        #12;
        check("reset", {pc_out, instr_out, instr_valid, halted}, 23'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(vec[i].fe, vec[i].st, vec[i].br, vec[i].off);
            check("vec", {pc_out, instr_out, instr_valid, halted}, {vec[i].pc, vec[i].ins, vec[i].v, 1'b0});
        end
        run_to(7);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 8'h03);
            check("stall", {pc_out, instr_out, instr_valid, halted}, {5'd7, memp[7], 1'b1, 1'b0});
        end
        step(1, 0, 0, 8'h00);
        check("resume", {pc_out, instr_out, instr_valid, halted}, {5'd8, memp[8], 1'b1, 1'b0});
        run_to(31);
        step(1, 0, 0, 8'h00);
        check("wrap", {pc_out, instr_out, instr_valid, halted}, {5'd0, 16'h380C, 1'b1, 1'b0});
        run_to(2);
        step(1, 0, 1, 8'hFB);
        check("bubble", {pc_out, instr_valid}, {5'd2, 1'b0});
        step(1, 0, 0, 8'h00);
        check("neg_branch", {pc_out, instr_out, instr_valid}, {5'd30, memp[30], 1'b1});
        run_to(12);
        #3 rst = 1'b1;
        #1 check("async_reset", {pc_out, instr_out, instr_valid, halted}, 23'd0);
        model_reset();
        fe = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        step(1, 0, 0, 8'h00);
        check("restart", {pc_out, instr_out, instr_valid}, {5'd0, 16'h380C, 1'b1});
        run_to(15);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 8'hFF);
            if (HALT_EN)
                check("halt", {pc_out, instr_out, instr_valid, halted}, {5'd15, memp[15], 1'b0, 1'b1});
            else
                check("self_loop", {pc_out, instr_out, instr_valid, halted}, {5'd15, memp[15], i[0], 1'b0});
        end
        rst = 1'b1;
        #1 check("halt_exit", {pc_out, instr_out, instr_valid, halted}, 23'd0);
        model_reset();
        fe = 1'b0; br = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            logic [7:0] o;
            o = 8'($urandom);
            if (o == 8'hFF) o = 8'h00;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, o);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
